// File: rtl/snake_pkg.sv
// Shared direction encoding and helpers for the snake turn scheduler.
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_U = 2'b00;
    localparam dir_t DIR_R = 2'b01;
    localparam dir_t DIR_D = 2'b10;
    localparam dir_t DIR_L = 2'b11;

    // Opposite heading: flips the vertical/horizontal sense bit.
    function automatic dir_t reverse(input dir_t d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/snake_debounce.sv
// One push-button: 2-flop synchroniser, stability counter and a one-cycle
// pulse on the debounced rising edge.
module snake_debounce #(
    parameter int N_DC = 20
) (
    input  logic Clk,
    input  logic Reset,
    input  logic raw_i,
    output logic press_o
);

    logic [1:0]      sync_q;
    logic            db_q;
    logic [N_DC-1:0] cnt_q;
    logic            press_q;

    // The counter only runs while the synchronised input disagrees with the
    // debounced level; any bounce back clears it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q  <= '0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            press_q <= 1'b0;
            if (sync_q[1] == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == '1) begin
                db_q    <= sync_q[1];
                cnt_q   <= '0;
                press_q <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/snake_dir_sched.sv
// Debounces the buttons, arbitrates same-cycle presses, filters illegal turns
// and releases one queued turn per game-step Tick.
module snake_dir_sched
    import snake_pkg::*;
#(
    parameter int   N_DC     = 20,
    parameter int   DEPTH    = 2,
    parameter dir_t INIT_DIR = DIR_R
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         BtnU,
    input  logic                         BtnR,
    input  logic                         BtnD,
    input  logic                         BtnL,
    input  logic                         BtnC,
    input  logic                         Tick,
    input  logic                         Enable,
    output logic [1:0]                   Dir,
    output logic                         StartPulse,
    output logic [$clog2(DEPTH+1)-1:0]   QCount,
    output logic                         Overflow
);

    localparam int QW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [4:0] btn_raw;
    logic [4:0] press;

    assign btn_raw = {BtnC, BtnL, BtnD, BtnR, BtnU};

    for (genvar i = 0; i < 5; i++) begin : g_db
        snake_debounce #(.N_DC(N_DC)) u_db (
            .Clk     (Clk),
            .Reset   (Reset),
            .raw_i   (btn_raw[i]),
            .press_o (press[i])
        );
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    dir_t          mem_q [DEPTH];
    dir_t          dir_q,    dir_d;
    logic [QW-1:0] cnt_q,    cnt_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          ovf_q,    ovf_d;
    logic          start_q,  start_d;

    dir_t          win;
    dir_t          ref_dir;
    logic [PW-1:0] tail_ptr;
    logic          legal, pop, push, full;

    assign tail_ptr = (wr_ptr_q == '0) ? PW'(DEPTH - 1) : wr_ptr_q - 1'b1;

    // NOTE: every combinational output gets a default first so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        win = DIR_U;
        if      (press[0]) win = DIR_U;
        else if (press[1]) win = DIR_R;
        else if (press[2]) win = DIR_D;
        else if (press[3]) win = DIR_L;

        ref_dir = (cnt_q != '0) ? mem_q[tail_ptr] : dir_q;
        legal   = (|press[3:0]) && Enable && (win != ref_dir) && (win != reverse(ref_dir));
        full    = (cnt_q == QW'(DEPTH));
        pop     = Tick && Enable && (cnt_q != '0);
        push    = legal && (!full || pop);

        dir_d    = dir_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        ovf_d    = ovf_q || (legal && full && !pop);
        start_d  = press[4];

        if (!Enable) begin
            dir_d    = INIT_DIR;
            cnt_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (pop) begin
                dir_d    = mem_q[rd_ptr_q];
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            dir_q    <= INIT_DIR;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            ovf_q    <= ovf_d;
            start_q  <= start_d;
        end
    end

    // NOTE: queue storage is not reset; entries are only read once cnt_q
    // says they were written, so clearing them would buy nothing.
    always_ff @(posedge Clk) begin
        if (push) mem_q[wr_ptr_q] <= win;
    end

    assign Dir        = dir_q;
    assign QCount     = cnt_q;
    assign Overflow   = ovf_q;
    assign StartPulse = start_q;

endmodule

// File: tb/tb_snake_dir_sched.sv
// Directed bench for snake_dir_sched with a short debounce window.
module tb_snake_dir_sched;

    localparam int N_DC  = 4;
    localparam int DEPTH = 2;
    localparam int QW    = $clog2(DEPTH + 1);

    localparam logic [4:0] B_U = 5'b00001;
    localparam logic [4:0] B_R = 5'b00010;
    localparam logic [4:0] B_D = 5'b00100;
    localparam logic [4:0] B_L = 5'b01000;
    localparam logic [4:0] B_C = 5'b10000;

    logic          Clk = 1'b0;
    logic          Reset, BtnU, BtnR, BtnD, BtnL, BtnC, Tick, Enable;
    logic [1:0]    Dir;
    logic          StartPulse;
    logic [QW-1:0] QCount;
    logic          Overflow;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    snake_dir_sched #(.N_DC(N_DC), .DEPTH(DEPTH), .INIT_DIR(2'b01)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .BtnU       (BtnU),
        .BtnR       (BtnR),
        .BtnD       (BtnD),
        .BtnL       (BtnL),
        .BtnC       (BtnC),
        .Tick       (Tick),
        .Enable     (Enable),
        .Dir        (Dir),
        .StartPulse (StartPulse),
        .QCount     (QCount),
        .Overflow   (Overflow)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_btns(input logic [4:0] v);
        {BtnC, BtnL, BtnD, BtnR, BtnU} = v;
    endtask

    task automatic pulse_tick();
        Tick = 1'b1;
        step();
        Tick = 1'b0;
    endtask

    // Clean press: held long enough to register, released long enough to settle.
    task automatic press_btns(input logic [4:0] v);
        set_btns(v);
        repeat (25) step();
        set_btns(5'b0);
        repeat (22) step();
    endtask

    // Press pulse lands 18 edges after the raw change; Tick is aligned to it.
    task automatic press_on_tick(input logic [4:0] v);
        set_btns(v);
        repeat (18) step();
        pulse_tick();
        set_btns(5'b0);
        repeat (22) step();
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (Dir !== 2'b01) begin errors++; $display("FAIL reset_dir: got %b expected 01", Dir); end
        checks++; if (QCount !== 2'd0) begin errors++; $display("FAIL reset_qcount: got %0d expected 0", QCount); end
        checks++; if (StartPulse !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", StartPulse); end
        checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", Overflow); end
    endtask

    task automatic test_idle_ticks();
        Enable = 1'b1;
        for (int t = 0; t < 3; t++) begin
            repeat (19) step();
            pulse_tick();
            checks++; if (Dir !== 2'b01) begin errors++; $display("FAIL idle_dir%0d: got %b expected 01", t, Dir); end
            checks++; if (QCount !== 2'd0) begin errors++; $display("FAIL idle_q%0d: got %0d expected 0", t, QCount); end
        end
        checks++; if (StartPulse !== 1'b0 || Overflow !== 1'b0) begin
            errors++; $display("FAIL idle_flags: got start=%b ovf=%b expected 0 0", StartPulse, Overflow);
        end
    endtask

    task automatic test_glitch();
        set_btns(B_U);
        repeat (3) step();
        set_btns(5'b0);
        repeat (30) step();
        checks++; if (QCount !== 2'd0) begin errors++; $display("FAIL glitch_q: got %0d expected 0", QCount); end
    endtask

    task automatic test_single_press();
        press_btns(B_U);
        checks++; if (QCount !== 2'd1) begin errors++; $display("FAIL single_q: got %0d expected 1", QCount); end
        checks++; if (Dir !== 2'b01) begin errors++; $display("FAIL single_dir_pre: got %b expected 01", Dir); end
        pulse_tick();
        checks++; if (Dir !== 2'b00) begin errors++; $display("FAIL single_dir: got %b expected 00", Dir); end
        checks++; if (QCount !== 2'd0) begin errors++; $display("FAIL single_q_post: got %0d expected 0", QCount); end
    endtask

    task automatic turn_right();
        press_btns(B_R);
        pulse_tick();
        checks++; if (Dir !== 2'b01) begin errors++; $display("FAIL turn_right: got %b expected 01", Dir); end
    endtask

    task automatic test_illegal();
        press_btns(B_L);
        checks++; if (QCount !== 2'd0) begin errors++; $display("FAIL reverse_q: got %0d expected 0", QCount); end
        press_btns(B_R);
        checks++; if (QCount !== 2'd0) begin errors++; $display("FAIL same_q: got %0d expected 0", QCount); end
        pulse_tick();
        checks++; if (Dir !== 2'b01) begin errors++; $display("FAIL illegal_dir: got %b expected 01", Dir); end
    endtask

    task automatic test_same_cycle();
        press_btns(B_U | B_L);
        checks++; if (QCount !== 2'd1) begin errors++; $display("FAIL arb_q: got %0d expected 1", QCount); end
        pulse_tick();
        checks++; if (Dir !== 2'b00) begin errors++; $display("FAIL arb_dir: got %b expected 00", Dir); end
    endtask

    task automatic test_empty_push_tick();
        press_on_tick(B_U);
        checks++; if (QCount !== 2'd1) begin errors++; $display("FAIL nobypass_q: got %0d expected 1", QCount); end
        checks++; if (Dir !== 2'b01) begin errors++; $display("FAIL nobypass_dir: got %b expected 01", Dir); end
        pulse_tick();
        checks++; if (Dir !== 2'b00) begin errors++; $display("FAIL nobypass_dir2: got %b expected 00", Dir); end
    endtask

    task automatic test_back_to_back();
        press_btns(B_U);
        press_btns(B_L);
        checks++; if (QCount !== 2'd2) begin errors++; $display("FAIL b2b_fill: got %0d expected 2", QCount); end
        press_on_tick(B_D);
        checks++; if (QCount !== 2'd2) begin errors++; $display("FAIL b2b_q: got %0d expected 2", QCount); end
        checks++; if (Dir !== 2'b00) begin errors++; $display("FAIL b2b_dir: got %b expected 00", Dir); end
        checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b expected 0", Overflow); end
        pulse_tick();
        checks++; if (Dir !== 2'b11) begin errors++; $display("FAIL b2b_dir2: got %b expected 11", Dir); end
        pulse_tick();
        checks++; if (Dir !== 2'b10) begin errors++; $display("FAIL b2b_dir3: got %b expected 10", Dir); end
        checks++; if (QCount !== 2'd0) begin errors++; $display("FAIL b2b_empty: got %0d expected 0", QCount); end
    endtask

    task automatic test_overflow();
        press_btns(B_U);
        press_btns(B_L);
        checks++; if (QCount !== 2'd2) begin errors++; $display("FAIL ovf_fill: got %0d expected 2", QCount); end
        press_btns(B_D);
        checks++; if (QCount !== 2'd2) begin errors++; $display("FAIL ovf_q: got %0d expected 2", QCount); end
        checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", Overflow); end
        pulse_tick();
        checks++; if (Dir !== 2'b00) begin errors++; $display("FAIL ovf_dir1: got %b expected 00", Dir); end
        pulse_tick();
        checks++; if (Dir !== 2'b11) begin errors++; $display("FAIL ovf_dir2: got %b expected 11", Dir); end
        checks++; if (QCount !== 2'd0) begin errors++; $display("FAIL ovf_empty: got %0d expected 0", QCount); end
    endtask

    task automatic test_disable();
        int highs;
        press_btns(B_U);
        press_btns(B_R);
        checks++; if (QCount !== 2'd2) begin errors++; $display("FAIL dis_fill: got %0d expected 2", QCount); end
        Enable = 1'b0;
        step();
        checks++; if (QCount !== 2'd0) begin errors++; $display("FAIL dis_q: got %0d expected 0", QCount); end
        checks++; if (Dir !== 2'b01) begin errors++; $display("FAIL dis_dir: got %b expected 01", Dir); end
        press_btns(B_U);
        checks++; if (QCount !== 2'd0) begin errors++; $display("FAIL dis_press: got %0d expected 0", QCount); end
        highs = 0;
        set_btns(B_C);
        for (int c = 0; c < 30; c++) begin
            step();
            if (StartPulse === 1'b1) highs++;
        end
        set_btns(5'b0);
        for (int c = 0; c < 22; c++) begin
            step();
            if (StartPulse === 1'b1) highs++;
        end
        checks++; if (highs != 1) begin errors++; $display("FAIL start_pulse: got %0d cycles expected 1", highs); end
        checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", Overflow); end
    endtask

    task automatic test_reset_mid_queue();
        Enable = 1'b1;
        press_btns(B_U);
        checks++; if (QCount !== 2'd1) begin errors++; $display("FAIL rst_fill: got %0d expected 1", QCount); end
        apply_reset();
        checks++; if (QCount !== 2'd0) begin errors++; $display("FAIL rst_q: got %0d expected 0", QCount); end
        checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", Overflow); end
        checks++; if (Dir !== 2'b01) begin errors++; $display("FAIL rst_dir: got %b expected 01", Dir); end
    endtask

    initial begin
        Reset  = 1'b1;
        Tick   = 1'b0;
        Enable = 1'b0;
        set_btns(5'b0);
        test_reset();
        test_idle_ticks();
        test_glitch();
        test_single_press();
        turn_right();
        test_illegal();
        test_same_cycle();
        turn_right();
        test_empty_push_tick();
        turn_right();
        test_back_to_back();
        turn_right();
        test_overflow();
        test_disable();
        test_reset_mid_queue();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
